// File: rtl/fractal_sync_rr_sched_pkg.sv
// Shared helpers for the fractal_sync round-robin scheduler.
// Provides index-width sizing used by the scheduler and its picker.
package fractal_sync_rr_sched_pkg;

   // Width of an index into n entries, never narrower than one bit.
   function automatic int unsigned idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/fractal_sync_rr_pick.sv
// Circular first-one finder: first set req_i bit at or after start_i.
// Ports: req_i mask, start_i pointer -> gnt_o one-hot, idx_o, found_o.
module fractal_sync_rr_pick
   import fractal_sync_rr_sched_pkg::*;
#(
   parameter int unsigned N = 4,
   localparam int unsigned W = idx_w(N)
) (
   input  logic [N-1:0] req_i,
   input  logic [W-1:0] start_i,
   output logic [N-1:0] gnt_o,
   output logic [W-1:0] idx_o,
   output logic         found_o
);

   logic [W:0] pos;

   always_comb begin
      gnt_o   = '0;
      idx_o   = '0;
      found_o = 1'b0;
      pos     = '0;
      for (int k = 0; k < int'(N); k++) begin
         pos = {1'b0, start_i} + (W+1)'(k);
         if (pos >= (W+1)'(N)) begin
            pos = pos - (W+1)'(N);
         end
         if (!found_o && req_i[pos[W-1:0]]) begin
            found_o             = 1'b1;
            idx_o               = pos[W-1:0];
            gnt_o[pos[W-1:0]]   = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fractal_sync_rr_sched.sv
// Round-robin scheduler: IN_PORTS FIFO sources onto OUT_PORTS registered
// valid/ready channels. Ports: clk_i, rst_ni, empty_i/element_i/pop_o per
// source, valid_o/element_o/ready_i per channel, starve_o per source, busy_o.
module fractal_sync_rr_sched
   import fractal_sync_rr_sched_pkg::*;
#(
   parameter int unsigned  IN_PORTS  = 4,
   parameter int unsigned  OUT_PORTS = 2,
   parameter type          elem_t    = logic,
   parameter int unsigned  STARVE_TH = 15,
   localparam int unsigned CNT_W     = $clog2(STARVE_TH + 1)
) (
   input  logic  clk_i,
   input  logic  rst_ni,
   input  logic  empty_i   [IN_PORTS],
   input  elem_t element_i [IN_PORTS],
   output logic  pop_o     [IN_PORTS],
   output logic  valid_o   [OUT_PORTS],
   output elem_t element_o [OUT_PORTS],
   input  logic  ready_i   [OUT_PORTS],
   output logic  starve_o  [IN_PORTS],
   output logic  busy_o
);

   localparam int unsigned PW = idx_w(IN_PORTS);

   logic [PW-1:0]        ptr_q, ptr_d;
   logic [OUT_PORTS-1:0] valid_q, free, found;
   elem_t                elem_q  [OUT_PORTS];
   logic [IN_PORTS-1:0]  req, pop;
   logic [IN_PORTS-1:0]  avail   [OUT_PORTS+1];
   logic [IN_PORTS-1:0]  gnt     [OUT_PORTS];
   logic [PW-1:0]        idx     [OUT_PORTS];
   logic [CNT_W-1:0]     cnt_q   [IN_PORTS];
   logic [CNT_W-1:0]     cnt_d   [IN_PORTS];
   logic [IN_PORTS-1:0]  starve_q;

   // Reset gates requests so no source is popped while held in reset.
   always_comb begin
      req = '0;
      for (int i = 0; i < int'(IN_PORTS); i++) begin
         req[i] = !empty_i[i] && rst_ni;
      end
   end

   // Slot chain: each free slot picks from what upstream slots left over.
   assign avail[0] = req;

   for (genvar j = 0; j < OUT_PORTS; j++) begin : g_slot
      assign free[j] = !valid_q[j] || ready_i[j];

      fractal_sync_rr_pick #(
         .N (IN_PORTS)
      ) u_pick (
         .req_i   (free[j] ? avail[j] : '0),
         .start_i (ptr_q),
         .gnt_o   (gnt[j]),
         .idx_o   (idx[j]),
         .found_o (found[j])
      );

      assign avail[j+1] = avail[j] & ~gnt[j];
   end

   assign pop = avail[0] & ~avail[OUT_PORTS];

   // Picks are consecutive in circular order, so the highest slot that
   // found a source holds the furthest pick.
   always_comb begin
      ptr_d = ptr_q;
      for (int j = 0; j < int'(OUT_PORTS); j++) begin
         if (found[j]) begin
            ptr_d = (idx[j] == PW'(IN_PORTS - 1)) ? '0 : idx[j] + 1'b1;
         end
      end
   end

   always_comb begin
      for (int i = 0; i < int'(IN_PORTS); i++) begin
         cnt_d[i] = cnt_q[i];
         if (empty_i[i] || pop[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] != CNT_W'(STARVE_TH)) begin
            cnt_d[i] = cnt_q[i] + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ptr_q    <= '0;
         valid_q  <= '0;
         starve_q <= '0;
         for (int j = 0; j < int'(OUT_PORTS); j++) begin
            elem_q[j] <= '0;
         end
         for (int i = 0; i < int'(IN_PORTS); i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         ptr_q <= ptr_d;
         for (int j = 0; j < int'(OUT_PORTS); j++) begin
            if (free[j]) begin
               valid_q[j] <= found[j];
               if (found[j]) begin
                  elem_q[j] <= element_i[idx[j]];
               end
            end
         end
         for (int i = 0; i < int'(IN_PORTS); i++) begin
            cnt_q[i]    <= cnt_d[i];
            starve_q[i] <= (cnt_d[i] == CNT_W'(STARVE_TH));
         end
      end
   end

   always_comb begin
      for (int i = 0; i < int'(IN_PORTS); i++) begin
         pop_o[i]    = pop[i];
         starve_o[i] = starve_q[i];
      end
      for (int j = 0; j < int'(OUT_PORTS); j++) begin
         valid_o[j]   = valid_q[j];
         element_o[j] = elem_q[j];
      end
   end

   assign busy_o = |valid_q;

endmodule

// File: tb/tb_fractal_sync_rr_sched.sv
// Self-checking bench for fractal_sync_rr_sched (4 sources, 2 channels).
// Table vectors, directed corner sequences and a random run vs a model.
module tb_fractal_sync_rr_sched;

   localparam int NI = 4;
   localparam int NO = 2;
   localparam int TH = 15;

   typedef logic [15:0] el_t;

   typedef struct {
      logic [NI-1:0] emp;
      logic [NO-1:0] rdy;
      logic [NI-1:0] pop;
      logic [NO-1:0] vld;
   } vec_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic empty    [NI];
   el_t  elem_in  [NI];
   logic pop      [NI];
   logic valid    [NO];
   el_t  elem_out [NO];
   logic ready    [NO];
   logic starve   [NI];
   logic busy;

   fractal_sync_rr_sched #(
      .IN_PORTS  (NI),
      .OUT_PORTS (NO),
      .elem_t    (el_t),
      .STARVE_TH (TH)
   ) dut (
      .clk_i     (clk),
      .rst_ni    (rst_n),
      .empty_i   (empty),
      .element_i (elem_in),
      .pop_o     (pop),
      .valid_o   (valid),
      .element_o (elem_out),
      .ready_i   (ready),
      .starve_o  (starve),
      .busy_o    (busy)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int n_hs  = 0;

   // Source model: per-source sequence tag and remaining count (-1 = endless).
   int seq  [NI];
   int left [NI];

   // Reference state of the scheduler.
   bit   m_valid [NO];
   el_t  m_elem  [NO];
   int   m_ptr;
   int   m_cnt   [NI];
   bit   seen    [int];

   logic [NI-1:0] last_pop, last_starve;
   logic [NO-1:0] last_valid;

   function automatic el_t tag(input int i);
      return el_t'((i << 12) | (seq[i] & 'hfff));
   endfunction

   function automatic logic [NI-1:0] pops();
      logic [NI-1:0] v;
      for (int i = 0; i < NI; i++) v[i] = pop[i];
      return v;
   endfunction

   function automatic logic [NI-1:0] starves();
      logic [NI-1:0] v;
      for (int i = 0; i < NI; i++) v[i] = starve[i];
      return v;
   endfunction

   function automatic logic [NO-1:0] valids();
      logic [NO-1:0] v;
      for (int j = 0; j < NO; j++) v[j] = valid[j];
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int j = 0; j < NO; j++) begin
         m_valid[j] = 1'b0;
         m_elem[j]  = '0;
      end
      for (int i = 0; i < NI; i++) m_cnt[i] = 0;
      m_ptr = 0;
      seen.delete();
   endtask

   task automatic chk_reset(input string nm);
      chk({nm, "_pop"}, pops(), '0);
      chk({nm, "_valid"}, valids(), '0);
      chk({nm, "_busy"}, busy, 1'b0);
      chk({nm, "_starve"}, starves(), '0);
      for (int j = 0; j < NO; j++) chk({nm, "_elem"}, elem_out[j], '0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      chk_reset("rst");
      rst_n = 1'b1;
   endtask

   // One clock cycle, entered and left on a falling edge.
   task automatic cycle(input logic [NI-1:0] emp_req,
                        input logic [NO-1:0] rdy);
      logic [NI-1:0] emp, epop, est;
      logic [NO-1:0] mv;
      int lst [$];
      int pick [NO];
      int n, last, s;
      for (int i = 0; i < NI; i++) begin
         emp[i]     = emp_req[i] || left[i] == 0;
         empty[i]   = emp[i];
         elem_in[i] = emp[i] ? el_t'(16'hdead) : tag(i);
         est[i]     = (m_cnt[i] == TH);
      end
      for (int j = 0; j < NO; j++) begin
         ready[j] = rdy[j];
         mv[j]    = m_valid[j];
      end
      #1;
      chk("valid", valids(), mv);
      chk("busy", busy, |mv);
      chk("starve", starves(), est);
      for (int j = 0; j < NO; j++) begin
         if (m_valid[j]) chk("element", elem_out[j], m_elem[j]);
      end
      for (int j = 0; j < NO; j++) begin
         if (m_valid[j] && rdy[j]) begin
            n_cmp++;
            n_hs++;
            if (seen.exists(int'(m_elem[j]))) begin
               n_bad++;
               $display("FAIL dup: element %0h delivered twice", m_elem[j]);
            end
            seen[int'(m_elem[j])] = 1'b1;
         end
      end
      // Non-empty sources in circular order from the pointer, handed out
      // to free slots in ascending slot order.
      for (int k = 0; k < NI; k++) begin
         s = (m_ptr + k) % NI;
         if (!emp[s]) lst.push_back(s);
      end
      n    = 0;
      last = -1;
      epop = '0;
      for (int j = 0; j < NO; j++) begin
         pick[j] = -1;
         if ((!m_valid[j] || rdy[j]) && n < lst.size()) begin
            pick[j]       = lst[n];
            n++;
            epop[pick[j]] = 1'b1;
            last          = pick[j];
         end
      end
      chk("pop", pops(), epop);
      last_pop    = pops();
      last_valid  = valids();
      last_starve = starves();
      @(posedge clk);
      for (int j = 0; j < NO; j++) begin
         if (!m_valid[j] || rdy[j]) begin
            m_valid[j] = (pick[j] >= 0);
            if (pick[j] >= 0) m_elem[j] = tag(pick[j]);
         end
      end
      if (last >= 0) m_ptr = (last + 1) % NI;
      for (int i = 0; i < NI; i++) begin
         if (emp[i] || epop[i]) m_cnt[i] = 0;
         else if (m_cnt[i] < TH) m_cnt[i]++;
         if (epop[i]) begin
            seq[i]++;
            if (left[i] > 0) left[i]--;
         end
      end
      @(negedge clk);
   endtask

   initial begin
      vec_t tbl [9];
      tbl[0] = '{4'b0000, 2'b11, 4'b0011, 2'b00};
      tbl[1] = '{4'b0000, 2'b11, 4'b1100, 2'b11};
      tbl[2] = '{4'b0000, 2'b11, 4'b0011, 2'b11};
      tbl[3] = '{4'b0000, 2'b11, 4'b1100, 2'b11};
      tbl[4] = '{4'b0111, 2'b10, 4'b1000, 2'b11};
      tbl[5] = '{4'b1111, 2'b00, 4'b0000, 2'b11};
      tbl[6] = '{4'b0000, 2'b01, 4'b0001, 2'b11};
      tbl[7] = '{4'b0000, 2'b11, 4'b0110, 2'b11};
      tbl[8] = '{4'b0000, 2'b10, 4'b1000, 2'b11};

      for (int i = 0; i < NI; i++) begin
         seq[i]     = 0;
         left[i]    = -1;
         empty[i]   = 1'b0;
         elem_in[i] = '0;
      end
      for (int j = 0; j < NO; j++) ready[j] = 1'b1;
      model_reset();
      repeat (3) @(negedge clk);
      chk_reset("init");
      rst_n = 1'b1;

      // Full load, single-source refill, stalls and pointer wrap.
      for (int t = 0; t < 9; t++) begin
         cycle(tbl[t].emp, tbl[t].rdy);
         chk($sformatf("tbl%0d_pop", t), last_pop, tbl[t].pop);
         chk($sformatf("tbl%0d_valid", t), last_valid, tbl[t].vld);
      end

      // Reset while slot 0 holds data.
      do_reset();
      cycle(4'b1010, 2'b11);
      chk("midrst_first_pop", last_pop, 4'b0101);
      rst_n = 1'b0;
      #1;
      chk("midrst_valid", valids(), '0);
      chk("midrst_pop", pops(), '0);
      chk("midrst_busy", busy, 1'b0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      cycle(4'b1010, 2'b11);
      chk("midrst_repick", last_pop, 4'b0101);
      cycle(4'b1111, 2'b00);
      chk("midrst_slot0_src", 32'(elem_out[0] >> 12), 0);
      chk("midrst_slot1_src", 32'(elem_out[1] >> 12), 2);

      // Starvation of source 1 behind two stalled slots.
      do_reset();
      cycle(4'b1100, 2'b11);
      repeat (TH) cycle(4'b1101, 2'b00);
      cycle(4'b1101, 2'b01);
      chk("starve_set", last_starve, 4'b0010);
      chk("starve_pop", last_pop, 4'b0010);
      cycle(4'b1111, 2'b00);
      chk("starve_clr", last_starve, 4'b0000);

      // One element per source, ready toggling 1,0,1.
      do_reset();
      for (int i = 0; i < NI; i++) left[i] = 1;
      n_hs = 0;
      for (int c = 0; c < 12; c++) begin
         cycle(4'b0000, (c % 3 == 1) ? 2'b00 : 2'b11);
      end
      chk("toggle_handshakes", n_hs, 4);
      chk("toggle_drained", valids(), '0);

      // Random traffic against the reference model.
      do_reset();
      for (int i = 0; i < NI; i++) left[i] = -1;
      for (int c = 0; c < 400; c++) begin
         cycle(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
